// File: rtl/dlsc_axi_decerr_slave_if.sv
// dlsc_axi_decerr_slave_if
//
// Purpose: bundles the AXI read-address, read-data, write-address, write-data
// and write-response channel signals seen by the default DECERR slave.
//
// Parameters:
//   DATA - read data width
//   LEN  - burst length field width (4 = AXI3, 8 = AXI4)
//   SID  - AXI ID width
//
// Modports:
//   master - the interconnect side (drives valids/IDs/lengths, ready for R/B)
//   slave  - the DECERR slave side (drives address/data readies, R and B)
interface dlsc_axi_decerr_slave_if #(
    parameter int DATA = 32,
    parameter int LEN  = 4,
    parameter int SID  = 1
);
    // Read address channel
    logic            ar_ready;
    logic            ar_valid;
    logic [SID-1:0]  ar_id;
    logic [LEN-1:0]  ar_len;

    // Read data channel
    logic            r_ready;
    logic            r_valid;
    logic            r_last;
    logic [SID-1:0]  r_id;
    logic [DATA-1:0] r_data;
    logic [1:0]      r_resp;

    // Write address channel
    logic            aw_ready;
    logic            aw_valid;
    logic [SID-1:0]  aw_id;
    logic [LEN-1:0]  aw_len;

    // Write data channel
    logic            w_ready;
    logic            w_valid;
    logic            w_last;

    // Write response channel
    logic            b_ready;
    logic            b_valid;
    logic [SID-1:0]  b_id;
    logic [1:0]      b_resp;

    modport master (
        input  ar_ready, r_valid, r_last, r_id, r_data, r_resp,
        input  aw_ready, w_ready, b_valid, b_id, b_resp,
        output ar_valid, ar_id, ar_len, r_ready,
        output aw_valid, aw_id, aw_len, w_valid, w_last, b_ready
    );

    modport slave (
        output ar_ready, r_valid, r_last, r_id, r_data, r_resp,
        output aw_ready, w_ready, b_valid, b_id, b_resp,
        input  ar_valid, ar_id, ar_len, r_ready,
        input  aw_valid, aw_id, aw_len, w_valid, w_last, b_ready
    );
endinterface

// File: rtl/dlsc_axi_decerr_slave.sv
// dlsc_axi_decerr_slave
//
// Purpose: default AXI slave for address ranges the interconnect decoder does
// not map. Every read burst returns len+1 beats of zero data with DECERR, and
// every write burst has its len+1 data beats swallowed and is answered with a
// single DECERR write response. Read and write engines are independent, each
// with at most one outstanding burst. Addresses are never looked at.
//
// Ports:
//   clk       - clock, all logic on the rising edge
//   rst       - synchronous active-high reset
//   axi       - slave modport of dlsc_axi_decerr_slave_if (AR/R/AW/W/B)
//   err_wlast - one-cycle pulse when an accepted W beat has w_last disagreeing
//               with the beat count (only with the optional checker)
//
// Optional feature: define DLSC_DECERR_WLAST_CHECK_EN to build the w_last
// checker. Without it err_wlast is tied low and w_last is ignored.
//
// All outputs come straight from flops; there is no combinational path from
// any input to any output.
module dlsc_axi_decerr_slave #(
    parameter int DATA = 32,
    parameter int LEN  = 4,
    parameter int SID  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    dlsc_axi_decerr_slave_if.slave axi,
    output logic                  err_wlast
);

    typedef enum logic {R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    r_state_t       r_state_q, r_state_d;
    logic           ar_ready_q, ar_ready_d;
    logic           r_valid_q, r_valid_d;
    logic           r_last_q, r_last_d;
    logic [SID-1:0] r_id_q, r_id_d;
    logic [LEN-1:0] rcnt_q, rcnt_d;

    w_state_t       w_state_q, w_state_d;
    logic           aw_ready_q, aw_ready_d;
    logic           w_ready_q, w_ready_d;
    logic           b_valid_q, b_valid_d;
    logic [SID-1:0] b_id_q, b_id_d;
    logic [LEN-1:0] wcnt_q, wcnt_d;

    // Handshakes use the registered readies so acceptance matches what the
    // master actually sees on the bus.
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
    assign ar_hs = axi.ar_valid & ar_ready_q;
    assign r_hs  = r_valid_q & axi.r_ready;
    assign aw_hs = axi.aw_valid & aw_ready_q;
    assign w_hs  = axi.w_valid & w_ready_q;
    assign b_hs  = b_valid_q & axi.b_ready;

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q  <= R_IDLE;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_last_q   <= 1'b0;
            r_id_q     <= '0;
            rcnt_q     <= '0;
            w_state_q  <= W_IDLE;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_id_q     <= '0;
            wcnt_q     <= '0;
        end else begin
            r_state_q  <= r_state_d;
            ar_ready_q <= ar_ready_d;
            r_valid_q  <= r_valid_d;
            r_last_q   <= r_last_d;
            r_id_q     <= r_id_d;
            rcnt_q     <= rcnt_d;
            w_state_q  <= w_state_d;
            aw_ready_q <= aw_ready_d;
            w_ready_q  <= w_ready_d;
            b_valid_q  <= b_valid_d;
            b_id_q     <= b_id_d;
            wcnt_q     <= wcnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs) r_state_d = R_DATA;
            R_DATA:  if (r_hs && rcnt_q == '0) r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE:  if (aw_hs) w_state_d = W_DATA;
            W_DATA:  if (w_hs && wcnt_q == '0) w_state_d = W_RESP;
            W_RESP:  if (b_hs) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    // Output logic: computes the next value of every registered output
    always_comb begin
        ar_ready_d = ar_ready_q;
        r_valid_d  = r_valid_q;
        r_last_d   = r_last_q;
        r_id_d     = r_id_q;
        rcnt_d     = rcnt_q;
        case (r_state_q)
            R_IDLE: begin
                ar_ready_d = 1'b1;
                r_valid_d  = 1'b0;
                r_last_d   = 1'b0;
                if (ar_hs) begin
                    ar_ready_d = 1'b0;
                    r_valid_d  = 1'b1;
                    r_last_d   = (axi.ar_len == '0);
                    r_id_d     = axi.ar_id;
                    rcnt_d     = axi.ar_len;
                end
            end
            R_DATA: begin
                if (r_hs) begin
                    if (rcnt_q == '0) begin
                        // Burst done; AR reopens so the idle cycle can accept.
                        ar_ready_d = 1'b1;
                        r_valid_d  = 1'b0;
                        r_last_d   = 1'b0;
                    end else begin
                        rcnt_d   = rcnt_q - 1'b1;
                        r_last_d = (rcnt_q == LEN'(1));
                    end
                end
            end
            default: begin
                ar_ready_d = 1'b0;
                r_valid_d  = 1'b0;
                r_last_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        aw_ready_d = aw_ready_q;
        w_ready_d  = w_ready_q;
        b_valid_d  = b_valid_q;
        b_id_d     = b_id_q;
        wcnt_d     = wcnt_q;
        case (w_state_q)
            W_IDLE: begin
                // W data arriving ahead of AW is held off until the address.
                aw_ready_d = 1'b1;
                w_ready_d  = 1'b0;
                b_valid_d  = 1'b0;
                if (aw_hs) begin
                    aw_ready_d = 1'b0;
                    w_ready_d  = 1'b1;
                    b_id_d     = axi.aw_id;
                    wcnt_d     = axi.aw_len;
                end
            end
            W_DATA: begin
                // Count-based termination: w_last is never consulted here.
                if (w_hs) begin
                    if (wcnt_q == '0) begin
                        w_ready_d = 1'b0;
                        b_valid_d = 1'b1;
                    end else begin
                        wcnt_d = wcnt_q - 1'b1;
                    end
                end
            end
            W_RESP: begin
                if (b_hs) begin
                    b_valid_d  = 1'b0;
                    aw_ready_d = 1'b1;
                end
            end
            default: begin
                aw_ready_d = 1'b0;
                w_ready_d  = 1'b0;
                b_valid_d  = 1'b0;
            end
        endcase
    end

    assign axi.ar_ready = ar_ready_q;
    assign axi.r_valid  = r_valid_q;
    assign axi.r_last   = r_last_q;
    assign axi.r_id     = r_id_q;
    assign axi.r_data   = {DATA{1'b0}};
    assign axi.r_resp   = 2'b11;
    assign axi.aw_ready = aw_ready_q;
    assign axi.w_ready  = w_ready_q;
    assign axi.b_valid  = b_valid_q;
    assign axi.b_id     = b_id_q;
    assign axi.b_resp   = 2'b11;

`ifdef DLSC_DECERR_WLAST_CHECK_EN
    logic err_wlast_q, err_wlast_d;

    // w_last must be high exactly on the beat where the count reaches zero.
    always_comb begin
        err_wlast_d = w_hs && (axi.w_last != (wcnt_q == '0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_wlast_q <= 1'b0;
        end else begin
            err_wlast_q <= err_wlast_d;
        end
    end

    assign err_wlast = err_wlast_q;
`else
    logic unused_w_last;
    assign unused_w_last = axi.w_last;
    assign err_wlast     = 1'b0;
`endif

endmodule

// File: tb/tb_dlsc_axi_decerr_slave.sv
module tb_dlsc_axi_decerr_slave;
    localparam int DATA = 32;
    localparam int LEN  = 4;
    localparam int SID  = 4;

    logic clk;
    logic rst;
    logic err_wlast;
    int   n_checks;
    int   n_fail;

    dlsc_axi_decerr_slave_if #(.DATA(DATA), .LEN(LEN), .SID(SID)) bus ();

    dlsc_axi_decerr_slave #(.DATA(DATA), .LEN(LEN), .SID(SID)) dut (
        .clk       (clk),
        .rst       (rst),
        .axi       (bus.slave),
        .err_wlast (err_wlast)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_burst(input logic [SID-1:0] id, input logic [LEN-1:0] len, input bit rnd);
        int   beats;
        int   cyc;
        bit   stalled;
        bit   go;
        logic p_last;
        logic [SID-1:0] p_id;
        bus.ar_id    = id;
        bus.ar_len   = len;
        bus.ar_valid = 1'b1;
        go  = 1'b0;
        cyc = 0;
        while (!go && cyc < 20) begin
            go = bus.ar_ready;
            step();
            cyc++;
        end
        bus.ar_valid = 1'b0;
        chk("ar_accept", go, 1);
        chk("ar_ready_busy", bus.ar_ready, 0);
        beats   = 0;
        stalled = 1'b0;
        p_last  = 1'b0;
        p_id    = '0;
        cyc     = 0;
        while (beats < int'(len) + 1 && cyc < 400) begin
            chk("r_valid", bus.r_valid, 1);
            if (stalled) begin
                chk("r_hold_last", bus.r_last, p_last);
                chk("r_hold_id", bus.r_id, p_id);
            end
            bus.r_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            chk("r_id", bus.r_id, id);
            chk("r_resp", bus.r_resp, 2'b11);
            chk("r_data", bus.r_data, 0);
            if (bus.r_ready) begin
                chk("r_last", bus.r_last, (beats == int'(len)));
                beats++;
                stalled = 1'b0;
            end else begin
                stalled = 1'b1;
                p_last  = bus.r_last;
                p_id    = bus.r_id;
            end
            step();
            cyc++;
        end
        bus.r_ready = 1'b0;
        chk("r_beats", beats, int'(len) + 1);
        chk("r_valid_done", bus.r_valid, 0);
        chk("ar_ready_done", bus.ar_ready, 1);
    endtask

    task automatic write_burst(input logic [SID-1:0] id, input logic [LEN-1:0] len,
                               input int last_pos, input int early, input int bdelay);
        int   beats;
        int   cyc;
        bit   go;
        logic exp_err;
        bus.w_last = 1'b0;
        for (int i = 0; i < early; i++) begin
            bus.w_valid = 1'b1;
            step();
            chk("w_ready_early", bus.w_ready, 0);
        end
        bus.aw_id    = id;
        bus.aw_len   = len;
        bus.aw_valid = 1'b1;
        go  = 1'b0;
        cyc = 0;
        while (!go && cyc < 20) begin
            go = bus.aw_ready;
            step();
            cyc++;
        end
        bus.aw_valid = 1'b0;
        chk("aw_accept", go, 1);
        beats   = 0;
        exp_err = 1'b0;
        cyc     = 0;
        while (!bus.b_valid && cyc < 400) begin
            chk("err_wlast", err_wlast, exp_err);
            bus.w_valid = 1'b1;
            bus.w_last  = (beats == last_pos);
            exp_err     = 1'b0;
            if (bus.w_ready) begin
`ifdef DLSC_DECERR_WLAST_CHECK_EN
                exp_err = ((beats == last_pos) != (beats == int'(len)));
`endif
                beats++;
            end
            step();
            cyc++;
        end
        bus.w_valid = 1'b0;
        bus.w_last  = 1'b0;
        chk("err_wlast_end", err_wlast, exp_err);
        chk("w_beats", beats, int'(len) + 1);
        chk("w_ready_resp", bus.w_ready, 0);
        chk("b_valid", bus.b_valid, 1);
        chk("b_id", bus.b_id, id);
        chk("b_resp", bus.b_resp, 2'b11);
        bus.b_ready = 1'b0;
        for (int i = 0; i < bdelay; i++) begin
            step();
            chk("b_hold_valid", bus.b_valid, 1);
            chk("b_hold_id", bus.b_id, id);
            chk("aw_ready_hold", bus.aw_ready, 0);
            chk("err_wlast_idle", err_wlast, 0);
        end
        bus.b_ready = 1'b1;
        step();
        bus.b_ready = 1'b0;
        chk("b_valid_done", bus.b_valid, 0);
        chk("aw_ready_done", bus.aw_ready, 1);
    endtask

    initial begin
        int rb;
        int wb;
        int bn;
        int cyc;
        n_checks = 0;
        n_fail   = 0;
        rst          = 1'b1;
        bus.ar_valid = 1'b0;
        bus.ar_id    = '0;
        bus.ar_len   = '0;
        bus.r_ready  = 1'b0;
        bus.aw_valid = 1'b0;
        bus.aw_id    = '0;
        bus.aw_len   = '0;
        bus.w_valid  = 1'b0;
        bus.w_last   = 1'b0;
        bus.b_ready  = 1'b0;

        // Reset values
        step();
        step();
        chk("rst_ar_ready", bus.ar_ready, 0);
        chk("rst_aw_ready", bus.aw_ready, 0);
        chk("rst_w_ready", bus.w_ready, 0);
        chk("rst_r_valid", bus.r_valid, 0);
        chk("rst_r_last", bus.r_last, 0);
        chk("rst_r_id", bus.r_id, 0);
        chk("rst_b_valid", bus.b_valid, 0);
        chk("rst_b_id", bus.b_id, 0);
        chk("rst_err_wlast", err_wlast, 0);
        rst = 1'b0;
        step();
        chk("post_rst_ar_ready", bus.ar_ready, 1);
        chk("post_rst_aw_ready", bus.aw_ready, 1);

        // AR id=3 len=3, r_ready held high
        read_burst(4'd3, 4'd3, 1'b0);
        step();

        // AW id=5 len=0, single beat, B stalled 10 cycles
        write_burst(4'd5, 4'd0, 0, 0, 10);

        // W presented 5 cycles before AW
        write_burst(4'd1, 4'd2, 2, 5, 0);

        // Single-beat read
        read_burst(4'd9, 4'd0, 1'b0);
        step();

        // Max length read with random backpressure
        read_burst(4'd12, 4'd15, 1'b1);
        step();

        // Max length write
        write_burst(4'd6, 4'd15, 15, 0, 2);

        // w_last early on beat 2 of a 4-beat burst
        write_burst(4'd2, 4'd3, 1, 0, 0);

        // Simultaneous AR and AW, len=7 each
        bus.ar_id    = 4'd7;
        bus.ar_len   = 4'd7;
        bus.aw_id    = 4'd10;
        bus.aw_len   = 4'd7;
        chk("both_ar_ready", bus.ar_ready, 1);
        chk("both_aw_ready", bus.aw_ready, 1);
        bus.ar_valid = 1'b1;
        bus.aw_valid = 1'b1;
        step();
        bus.ar_valid = 1'b0;
        bus.aw_valid = 1'b0;
        chk("both_r_valid", bus.r_valid, 1);
        chk("both_w_ready", bus.w_ready, 1);
        rb  = 0;
        wb  = 0;
        bn  = 0;
        cyc = 0;
        bus.r_ready = 1'b1;
        bus.b_ready = 1'b1;
        while (!(rb == 8 && bn == 1) && cyc < 100) begin
            if (bus.r_valid) begin
                chk("both_r_last", bus.r_last, (rb == 7));
                chk("both_r_id", bus.r_id, 4'd7);
                rb++;
            end
            bus.w_valid = (wb < 8);
            bus.w_last  = (wb == 7);
            if (bus.w_valid && bus.w_ready) wb++;
            if (bus.b_valid) begin
                chk("both_b_id", bus.b_id, 4'd10);
                bn++;
            end
            step();
            cyc++;
        end
        bus.r_ready = 1'b0;
        bus.b_ready = 1'b0;
        bus.w_valid = 1'b0;
        bus.w_last  = 1'b0;
        chk("both_r_beats", rb, 8);
        chk("both_w_beats", wb, 8);
        chk("both_b_count", bn, 1);
        step();
        chk("both_ar_ready_done", bus.ar_ready, 1);
        chk("both_aw_ready_done", bus.aw_ready, 1);

        // Reset in the middle of a read burst
        bus.ar_id    = 4'd11;
        bus.ar_len   = 4'd15;
        bus.ar_valid = 1'b1;
        step();
        bus.ar_valid = 1'b0;
        bus.r_ready  = 1'b1;
        step();
        step();
        step();
        chk("mid_r_valid", bus.r_valid, 1);
        rst         = 1'b1;
        bus.r_ready = 1'b0;
        step();
        chk("mid_rst_r_valid", bus.r_valid, 0);
        chk("mid_rst_r_last", bus.r_last, 0);
        chk("mid_rst_r_id", bus.r_id, 0);
        chk("mid_rst_ar_ready", bus.ar_ready, 0);
        chk("mid_rst_b_valid", bus.b_valid, 0);
        rst = 1'b0;
        step();
        chk("mid_rel_ar_ready", bus.ar_ready, 1);
        chk("mid_rel_r_valid", bus.r_valid, 0);
        step();
        chk("mid_idle_r_valid", bus.r_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
